uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- UART transmit framer that consumes the divided baud clock produced by the clock divider.
- Accepts parallel bytes over a valid/ready handshake and shifts each one out as an asynchronous serial frame: start bit, data LSB first, optional parity, then stop bit(s).
- Runs entirely in the system clock domain. The baud clock is never used as a clock; its rising edges act as bit-period ticks.

Parameters:
- DATA_BITS, 8, data bits per frame; supported range 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd; other values unsupported.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- baud_in  input  1  divided baud clock, registered in the clk domain; each rising edge = one bit tick.
- tx_data  input  DATA_BITS  byte to transmit; sampled only on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  framer can accept a byte this cycle.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  frame in progress or pending; equals ~tx_ready.

Behaviour:
- Tick generation:
  - baud_q <= baud_in each cycle.
  - tick = baud_in & ~baud_q, so each rising edge gives exactly one tick.
  - baud_in held high for many cycles gives one tick only.
- Reset (rst = 0, immediate):
  - tx = 1, state = IDLE, tx_ready = 1, busy = 0, baud_q = 0.
  - bit counter = 0, pending = 0.
  - Any in-flight or pending byte is discarded.
- Handshake:
  - Transfer occurs on a clk edge where tx_valid & tx_ready.
  - tx_data is copied into the shift register; later changes on tx_data are ignored.
  - tx_ready drops on the following cycle.
  - tx_valid while tx_ready = 0 is ignored and causes no error.
- tx_ready is 1 in exactly two cases:
  - in IDLE;
  - during the last stop-bit period when pending = 0.
- State machine (every transition below except the IDLE acceptance happens only on tick; tx is updated at the same edge):
  - IDLE: tx = 1. On acceptance, go to SYNC.
  - SYNC: tx = 1. On tick, go to START and set tx = 0. This aligns the start bit to a full bit period.
  - START: on tick, go to DATA, set tx = shift[0], bit_cnt = 0.
  - DATA: on tick, if bit_cnt == DATA_BITS-1:
    - PARITY != 0: go to PARITY, set tx = parity bit.
    - PARITY == 0: go to STOP, set tx = 1.
    - Otherwise shift right, bit_cnt + 1, tx = next bit.
  - PARITY: on tick, go to STOP, set tx = 1.
    - Even parity bit = XOR of the data bits.
    - Odd parity bit = XNOR of the data bits.
  - STOP: tx = 1; counts STOP_BITS ticks. On the tick that ends the final stop bit:
    - pending = 1: go to START, set tx = 0, clear pending. No idle gap between frames.
    - pending = 0: go to IDLE.
- Acceptance during the last stop bit:
  - Latches the byte and sets pending = 1.
  - The shift register is free at that point, because the last data/parity bit has already been driven.
- Simultaneous events:
  - A tick and an acceptance in the same cycle while in IDLE: accept, and enter SYNC. That tick is not used.
  - A tick and an acceptance in the same cycle during the last stop bit: accept and go directly to START.
- Widths:
  - bit_cnt is wide enough for DATA_BITS-1.
  - Comparisons are against sized constants to avoid implicit 32-bit extension.
- Timing:
  - tx changes exactly 1 clk after the baud_in rising edge is registered.
  - Each serial bit lasts exactly one baud_in period.

Test Plan:
- Reset: drive rst = 0 mid-operation. Required: tx = 1, tx_ready = 1, busy = 0 asynchronously, before any clk edge.
- 8N1, send 0xA5 from IDLE. Required: one idle bit period, then tx = 0, 1,0,1,0,0,1,0,1, then 1. Each bit spans exactly one baud_in period; tx_ready returns to 1 during the stop bit.
- Back-to-back: hold tx_valid with 0x00 then 0xFF. Required: the second byte is accepted during the first stop bit, and its start bit begins on the tick that ends that stop bit, with zero idle gap. Serial sequence: 0,00000000,1,0,11111111,1.
- PARITY = 2, STOP_BITS = 2, send 0x03. Required: start 0, data 1,1,0,0,0,0,0,0, parity 1, stop 1,1, then IDLE.
- Reset during DATA bit 3, then send 0x5A after release. Required: tx = 1 immediately and the partial frame is discarded. The following frame is 0,0,1,0,1,1,0,1,0,1.
- Busy and tick robustness:
  - Pulse tx_valid with 0x11 during DATA. Required: ignored; the frame in progress is unaffected.
  - Hold baud_in high for 50 clk. Required: exactly one bit advance.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer.
// Serialises one parallel word per valid/ready handshake into an asynchronous
// frame: start bit, data LSB first, optional parity, one or two stop bits.
// The divided baud clock is only sampled; each rising edge is one bit tick.
// A word offered during the final stop bit is held as pending so consecutive
// frames run back-to-back with no idle gap.
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  // Bit counter only has to reach DATA_BITS-1.
  localparam int                CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  // Stop-bit counter index of the final stop bit (0 for one stop bit, 1 for two).
  localparam logic              STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                 state_q;
  logic                   baud_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   stop_cnt_q;
  logic                   pend_q;
  logic                   tx_q;

  logic                   tick;
  logic                   accept;
  logic                   ready_w;
  logic                   last_stop;
  logic                   par_d;
  logic [DATA_BITS-1:0]   shift_d;

  // Delay the baud input one cycle so its rising edge can be detected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q <= 1'b0;
    end else begin
      baud_q <= baud_in;
    end
  end

  // Tick, handshake and parity decode from current state and inputs.
  always_comb begin
    tick      = baud_in & ~baud_q;
    last_stop = (state_q == S_STOP) && (stop_cnt_q == STOP_LAST);
    ready_w   = (state_q == S_IDLE) || (last_stop && !pend_q);
    accept    = tx_valid & ready_w;
    // Odd parity inverts the data XOR so the frame holds an odd count of ones.
    par_d     = (PARITY == 2) ? ~(^tx_data) : (^tx_data);
  end

  // Next shift-register contents: load on acceptance, shift after each data bit.
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      shift_d = tx_data;
    end else if (tick && (state_q == S_DATA) && (bit_cnt_q != LAST_BIT)) begin
      shift_d = shift_q >> 1;
    end
  end

  // Data holding registers; only ever read after a load, so no reset needed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (accept) begin
      par_q <= par_d;
    end
  end

  // Frame sequencer with registered serial output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          // A tick arriving together with the word is deliberately not used.
          if (accept) begin
            state_q <= S_SYNC;
          end
        end

        S_SYNC: begin
          // Waiting for a tick lines the start bit up with a full bit period.
          if (tick) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end

        S_START: begin
          if (tick) begin
            state_q   <= S_DATA;
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end

        S_DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              if (PARITY != 0) begin
                state_q <= S_PAR;
                tx_q    <= par_q;
              end else begin
                state_q    <= S_STOP;
                tx_q       <= 1'b1;
                stop_cnt_q <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              tx_q      <= shift_q[1];
            end
          end
        end

        S_PAR: begin
          if (tick) begin
            state_q    <= S_STOP;
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end

        S_STOP: begin
          tx_q <= 1'b1;
          if (tick) begin
            if (last_stop) begin
              // A word taken now or earlier in this stop bit starts immediately.
              if (pend_q || accept) begin
                state_q <= S_START;
                tx_q    <= 1'b0;
                pend_q  <= 1'b0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end else if (accept) begin
            pend_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_w;
  assign busy     = ~ready_w;

endmodule
